// File: rtl/pipe_pkg.sv
// Shared definitions for the picoMIPS pipelined datapath: ALU codes, multiplier
// FSM states and the flag bundle.
package pipe_pkg;

    // ALU function codes, held wide so any A_SIZE up to 16 compares cleanly.
    localparam logic [15:0] AluAdd   = 16'd0;
    localparam logic [15:0] AluSub   = 16'd1;
    localparam logic [15:0] AluAnd   = 16'd2;
    localparam logic [15:0] AluOr    = 16'd3;
    localparam logic [15:0] AluXor   = 16'd4;
    localparam logic [15:0] AluPassB = 16'd5;
    localparam logic [15:0] AluMul   = 16'd6;

    typedef enum logic [1:0] {
        MulIdle,
        MulBusy,
        MulDone
    } mul_state_t;

    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/pipe_datapath_seq_mul.sv
// n-cycle unsigned shift-add multiplier. Operands are latched on i_start while
// idle; after N busy cycles o_done is high for one cycle with the upper N bits
// of the 2N-bit product on o_hi.
module seq_mul
    import pipe_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_idle,
    output logic         o_done,
    output logic [N-1:0] o_hi
);
    localparam int unsigned CntW = $clog2(N);

    mul_state_t     r_state;
    mul_state_t     w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [N-1:0]   r_a;
    logic [2*N-1:0] r_p;
    logic [N:0]     w_sum;
    logic           w_last;

    assign w_last = (r_cnt == CntW'(N - 1));
    // Upper half plus multiplicand when the current multiplier bit is set.
    assign w_sum  = {1'b0, r_p[2*N-1:N]} + (r_p[0] ? {1'b0, r_a} : '0);
    assign o_hi   = r_p[2*N-1:N];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MulIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and status outputs.
    always_comb begin
        w_state_d = r_state;
        o_idle    = 1'b0;
        o_done    = 1'b0;
        unique case (r_state)
            MulIdle: begin
                o_idle = 1'b1;
                if (i_start) begin
                    w_state_d = MulBusy;
                end
            end
            MulBusy: begin
                if (w_last) begin
                    w_state_d = MulDone;
                end
            end
            MulDone: begin
                o_done    = 1'b1;
                w_state_d = MulIdle;
            end
            default: w_state_d = MulIdle;
        endcase
    end

    // Product register: load on start, one shift-add step per busy cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_p   <= '0;
        end else if ((r_state == MulIdle) && i_start) begin
            r_cnt <= '0;
            r_a   <= i_a;
            r_p   <= {{N{1'b0}}, i_b};
        end else if (r_state == MulBusy) begin
            r_cnt <= r_cnt + CntW'(1);
            r_p   <= {w_sum, r_p[N-1:1]};
        end
    end

endmodule

// File: rtl/pipe_datapath.sv
// picoMIPS datapath: register file with WB-stage forwarding, single-cycle ALU,
// registered write-back with flags, and a multi-cycle multiplier that stalls
// instruction issue while it runs.
module pipe_datapath
    import pipe_pkg::*;
#(
    parameter int unsigned n      = 8,
    parameter int unsigned A_SIZE = 3,
    parameter int unsigned R_SIZE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        SW,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [A_SIZE-1:0] ALUfunc,
    input  logic              imm,
    input  logic              immswitches,
    input  logic [R_SIZE-1:0] Raddr1,
    input  logic [n-1:0]      Raddr2,
    input  logic [R_SIZE-1:0] Waddr,
    input  logic              we,
    output logic [n-1:0]      displayResult,
    output logic              result_valid,
    output logic              flag_z,
    output logic              flag_c
);
    localparam int NumRegs = 2 ** R_SIZE;

    logic [n-1:0]      r_gpr [NumRegs];
    logic [n-1:0]      r_wb_data;
    logic [R_SIZE-1:0] r_wb_addr;
    logic              r_wb_we;
    logic              r_valid;
    flags_t            r_flags;
    logic [R_SIZE-1:0] r_mul_waddr;
    logic              r_mul_we;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_idle;
    logic              w_mul_done;
    logic [n-1:0]      w_mul_hi;
    logic [15:0]       w_func;
    logic [n-1:0]      w_sw;
    logic [R_SIZE-1:0] w_rb_addr;
    logic [n-1:0]      w_a;
    logic [n-1:0]      w_rf_b;
    logic [n-1:0]      w_b;
    logic [n:0]        w_wide;
    logic [n-1:0]      w_alu_res;
    logic              w_alu_c;
    logic              w_alu_def;
    logic [n-1:0]      w_wb_data_d;
    logic [R_SIZE-1:0] w_wb_addr_d;
    logic              w_wb_we_d;
    logic              w_load;
    flags_t            w_flags_d;
    logic              w_unused_sw;

    assign w_func      = 16'(ALUfunc);
    assign w_sw        = n'(SW);
    assign w_unused_sw = ^SW;
    assign w_rb_addr   = Raddr2[R_SIZE-1:0];
    assign instr_ready = w_mul_idle;
    assign w_accept    = instr_valid && instr_ready;
    assign w_is_mul    = (w_func == AluMul);
    assign w_mul_start = w_accept && w_is_mul;

    assign displayResult = r_wb_data;
    assign result_valid  = r_valid;
    assign flag_z        = r_flags.z;
    assign flag_c        = r_flags.c;

    // Operand fetch; r0 is hard zero and never forwarded.
    always_comb begin
        w_a = (Raddr1 == '0) ? '0 : r_gpr[Raddr1];
        if (r_wb_we && (r_wb_addr == Raddr1) && (Raddr1 != '0)) begin
            w_a = r_wb_data;
        end
        w_rf_b = (w_rb_addr == '0) ? '0 : r_gpr[w_rb_addr];
        if (r_wb_we && (r_wb_addr == w_rb_addr) && (w_rb_addr != '0)) begin
            w_rf_b = r_wb_data;
        end
        if (imm) begin
            w_b = immswitches ? w_sw : Raddr2;
        end else begin
            w_b = w_rf_b;
        end
    end

    // Single-cycle ALU; MUL and unknown codes fall to the not-defined path.
    always_comb begin
        w_wide    = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_def = 1'b1;
        case (w_func)
            AluAdd: begin
                w_wide    = {1'b0, w_a} + {1'b0, w_b};
                w_alu_res = w_wide[n-1:0];
                w_alu_c   = w_wide[n];
            end
            AluSub: begin
                // Bit n of the extended difference is the unsigned borrow.
                w_wide    = {1'b0, w_a} - {1'b0, w_b};
                w_alu_res = w_wide[n-1:0];
                w_alu_c   = w_wide[n];
            end
            AluAnd:   w_alu_res = w_a & w_b;
            AluOr:    w_alu_res = w_a | w_b;
            AluXor:   w_alu_res = w_a ^ w_b;
            AluPassB: w_alu_res = w_b;
            default:  w_alu_def = 1'b0;
        endcase
    end

    // Write-back stage next state: multiplier completion or a single-cycle op.
    always_comb begin
        w_load      = 1'b0;
        w_wb_data_d = r_wb_data;
        w_wb_addr_d = r_wb_addr;
        w_wb_we_d   = 1'b0;
        w_flags_d   = r_flags;
        if (w_mul_done) begin
            w_load      = 1'b1;
            w_wb_data_d = w_mul_hi;
            w_wb_addr_d = r_mul_waddr;
            w_wb_we_d   = r_mul_we;
            w_flags_d.z = (w_mul_hi == '0);
            w_flags_d.c = 1'b0;
        end else if (w_accept && !w_is_mul) begin
            w_load = 1'b1;
            if (w_alu_def) begin
                w_wb_data_d = w_alu_res;
                w_wb_addr_d = Waddr;
                w_wb_we_d   = we;
                w_flags_d.z = (w_alu_res == '0);
                w_flags_d.c = w_alu_c;
            end else begin
                w_wb_data_d = '0;
            end
        end
    end

    // Write-back and multiplier destination registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_data   <= '0;
            r_wb_addr   <= '0;
            r_wb_we     <= 1'b0;
            r_valid     <= 1'b0;
            r_flags     <= '0;
            r_mul_waddr <= '0;
            r_mul_we    <= 1'b0;
        end else begin
            r_wb_data <= w_wb_data_d;
            r_wb_addr <= w_wb_addr_d;
            r_wb_we   <= w_wb_we_d;
            r_valid   <= w_load;
            r_flags   <= w_flags_d;
            if (w_mul_start) begin
                r_mul_waddr <= Waddr;
                r_mul_we    <= we;
            end
        end
    end

    // Register file commit from the write-back stage; r0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (r_wb_we && (r_wb_addr != '0)) begin
            r_gpr[r_wb_addr] <= r_wb_data;
        end
    end

    seq_mul #(
        .N(n)
    ) u_seq_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(w_mul_start),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_idle (w_mul_idle),
        .o_done (w_mul_done),
        .o_hi   (w_mul_hi)
    );

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed self-checking bench for pipe_datapath (n=8, A_SIZE=3, R_SIZE=3).
module tb_pipe_datapath;

    localparam logic [2:0] FAdd   = 3'd0;
    localparam logic [2:0] FSub   = 3'd1;
    localparam logic [2:0] FAnd   = 3'd2;
    localparam logic [2:0] FOr    = 3'd3;
    localparam logic [2:0] FXor   = 3'd4;
    localparam logic [2:0] FPassB = 3'd5;
    localparam logic [2:0] FMul   = 3'd6;
    localparam logic [2:0] FUndef = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] SW;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] ALUfunc;
    logic       imm;
    logic       immswitches;
    logic [2:0] Raddr1;
    logic [7:0] Raddr2;
    logic [2:0] Waddr;
    logic       we;
    logic [7:0] displayResult;
    logic       result_valid;
    logic       flag_z;
    logic       flag_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_datapath #(
        .n     (8),
        .A_SIZE(3),
        .R_SIZE(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SW           (SW),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .ALUfunc      (ALUfunc),
        .imm          (imm),
        .immswitches  (immswitches),
        .Raddr1       (Raddr1),
        .Raddr2       (Raddr2),
        .Waddr        (Waddr),
        .we           (we),
        .displayResult(displayResult),
        .result_valid (result_valid),
        .flag_z       (flag_z),
        .flag_c       (flag_c)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic i_imm, input logic i_sw,
                         input logic [2:0] ra, input logic [7:0] rb,
                         input logic [2:0] wa, input logic w);
        instr_valid = 1'b1;
        ALUfunc     = f;
        imm         = i_imm;
        immswitches = i_sw;
        Raddr1      = ra;
        Raddr2      = rb;
        Waddr       = wa;
        we          = w;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] d, input logic z,
                              input logic c);
        chk({tag, ".valid"}, 16'(result_valid), 16'd1);
        chk({tag, ".data"}, 16'(displayResult), 16'(d));
        chk({tag, ".z"}, 16'(flag_z), 16'(z));
        chk({tag, ".c"}, 16'(flag_c), 16'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        SW    = '0;
        drive(FAdd, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0);
        instr_valid = 1'b0;
        repeat (2) step();
        chk("rst.data", 16'(displayResult), 16'd0);
        chk("rst.valid", 16'(result_valid), 16'd0);
        chk("rst.z", 16'(flag_z), 16'd0);
        chk("rst.c", 16'(flag_c), 16'd0);
        rst_n = 1'b1;
        step();
        chk("rst.ready", 16'(instr_ready), 16'd1);
        chk("rst.novalid", 16'(result_valid), 16'd0);

        // Back-to-back with forwarding.
        drive(FAdd, 1'b1, 1'b0, 3'd0, 8'h05, 3'd1, 1'b1);
        step();
        expect_res("add_r1", 8'h05, 1'b0, 1'b0);
        drive(FAdd, 1'b1, 1'b0, 3'd1, 8'h03, 3'd2, 1'b1);
        step();
        expect_res("fwd_r2", 8'h08, 1'b0, 1'b0);
        drive(FSub, 1'b0, 1'b0, 3'd1, 8'h02, 3'd3, 1'b1);
        step();
        expect_res("sub_r3", 8'hFD, 1'b0, 1'b1);
        instr_valid = 1'b0;
        step();
        chk("hold.valid", 16'(result_valid), 16'd0);
        chk("hold.data", 16'(displayResult), 16'h00FD);

        // Logic ops on r1 = 0x05.
        drive(FAnd, 1'b1, 1'b0, 3'd1, 8'h0C, 3'd0, 1'b0);
        step();
        expect_res("and", 8'h04, 1'b0, 1'b0);
        drive(FOr, 1'b1, 1'b0, 3'd1, 8'h0A, 3'd0, 1'b0);
        step();
        expect_res("or", 8'h0F, 1'b0, 1'b0);
        drive(FXor, 1'b1, 1'b0, 3'd1, 8'h0F, 3'd0, 1'b0);
        step();
        expect_res("xor", 8'h0A, 1'b0, 1'b0);

        // Switch immediate (truncated to 8 bits), carry-out wrap, undefined op.
        SW = 10'h3FF;
        drive(FPassB, 1'b1, 1'b1, 3'd0, 8'h00, 3'd6, 1'b1);
        step();
        expect_res("sw_r6", 8'hFF, 1'b0, 1'b0);
        drive(FAdd, 1'b1, 1'b0, 3'd6, 8'h01, 3'd4, 1'b1);
        step();
        expect_res("add_wrap", 8'h00, 1'b1, 1'b1);
        drive(FUndef, 1'b1, 1'b0, 3'd1, 8'h33, 3'd6, 1'b1);
        step();
        expect_res("undef", 8'h00, 1'b1, 1'b1);
        drive(FPassB, 1'b1, 1'b0, 3'd0, 8'h10, 3'd7, 1'b1);
        step();
        expect_res("passb", 8'h10, 1'b0, 1'b0);
        drive(FPassB, 1'b0, 1'b0, 3'd0, 8'h06, 3'd0, 1'b0);
        step();
        expect_res("r6_kept", 8'hFF, 1'b0, 1'b0);

        // Multiply 0x80 * 0x40 with a new instruction held during the stall.
        drive(FPassB, 1'b1, 1'b0, 3'd0, 8'h80, 3'd1, 1'b1);
        step();
        expect_res("r1_80", 8'h80, 1'b0, 1'b0);
        drive(FMul, 1'b1, 1'b0, 3'd1, 8'h40, 3'd2, 1'b1);
        step();
        drive(FPassB, 1'b1, 1'b0, 3'd0, 8'h55, 3'd5, 1'b1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("mul.busy_ready%0d", k), 16'(instr_ready), 16'd0);
            chk($sformatf("mul.busy_valid%0d", k), 16'(result_valid), 16'd0);
            step();
        end
        chk("mul.ready_back", 16'(instr_ready), 16'd1);
        expect_res("mul", 8'h20, 1'b0, 1'b0);
        step();
        expect_res("after_mul", 8'h55, 1'b0, 1'b0);
        drive(FPassB, 1'b0, 1'b0, 3'd0, 8'h02, 3'd0, 1'b0);
        step();
        expect_res("r2_mul", 8'h20, 1'b0, 1'b0);

        // r0 stays zero through both the forward and register-file paths.
        drive(FPassB, 1'b1, 1'b0, 3'd0, 8'h7F, 3'd0, 1'b1);
        step();
        expect_res("r0_wr", 8'h7F, 1'b0, 1'b0);
        drive(FAdd, 1'b1, 1'b0, 3'd0, 8'h01, 3'd5, 1'b1);
        step();
        expect_res("r0_fwd", 8'h01, 1'b0, 1'b0);
        drive(FAdd, 1'b1, 1'b0, 3'd0, 8'h02, 3'd3, 1'b1);
        step();
        expect_res("r0_rf", 8'h02, 1'b0, 1'b0);

        // Reset in the middle of a multiply.
        drive(FMul, 1'b1, 1'b0, 3'd6, 8'h02, 3'd1, 1'b1);
        step();
        instr_valid = 1'b0;
        repeat (3) step();
        chk("mulrst.busy", 16'(instr_ready), 16'd0);
        rst_n = 1'b0;
        step();
        chk("mulrst.valid", 16'(result_valid), 16'd0);
        chk("mulrst.data", 16'(displayResult), 16'd0);
        chk("mulrst.z", 16'(flag_z), 16'd0);
        chk("mulrst.c", 16'(flag_c), 16'd0);
        rst_n = 1'b1;
        step();
        chk("mulrst.ready", 16'(instr_ready), 16'd1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("mulrst.quiet%0d", k), 16'(result_valid), 16'd0);
            step();
        end
        for (int r = 1; r < 8; r++) begin
            drive(FPassB, 1'b0, 1'b0, 3'd0, 8'(r), 3'd0, 1'b0);
            step();
            expect_res($sformatf("clr_r%0d", r), 8'h00, 1'b1, 1'b0);
        end
        instr_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
